// File: rtl/pixel_window_reader_pkg.sv
// Shared definitions for the pixel window reader: pixel memory address
// layout, channel codes, image geometry and the reader FSM state type.
package pixel_pkg;

  localparam int unsigned IMG_W   = 32;
  localparam int unsigned IMG_H   = 32;
  localparam int unsigned TAP_CNT = 9;
  localparam int unsigned COORD_W = 5;

  // Pixel memory address fields: [11:10] channel, [9:5] row, [4:0] col
  localparam int unsigned COL_LSB = 0;
  localparam int unsigned ROW_LSB = 5;
  localparam int unsigned CH_LSB  = 10;

  localparam logic [1:0] RED   = 2'b00;
  localparam logic [1:0] GREEN = 2'b01;
  localparam logic [1:0] BLUE  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rd_state_t;

  function automatic logic [CH_LSB+1:0] pix_addr(input logic [1:0]         ch,
                                                 input logic [COORD_W-1:0] row,
                                                 input logic [COORD_W-1:0] col);
    return {ch, row, col};
  endfunction

endpackage

// File: rtl/pixel_win_counter.sv
// Nested window scan counters: kx fastest, then ky, then col, then row.
// Bounds depend on PIXEL_WIN_PAD_EN: defined -> positions 0..31 (padded),
// undefined -> positions 1..30 (valid convolution only).
module pixel_win_counter
  import pixel_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               advance_i,
  output logic [1:0]         kx_o,
  output logic [1:0]         ky_o,
  output logic [COORD_W-1:0] col_o,
  output logic [COORD_W-1:0] row_o,
  output logic               last_tap_o,
  output logic               last_pixel_o
);

`ifdef PIXEL_WIN_PAD_EN
  localparam logic [COORD_W-1:0] COL_MIN = '0;
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_MIN = '0;
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(IMG_H - 1);
`else
  localparam logic [COORD_W-1:0] COL_MIN = COORD_W'(1);
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(IMG_W - 2);
  localparam logic [COORD_W-1:0] ROW_MIN = COORD_W'(1);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(IMG_H - 2);
`endif

  logic [1:0]         kx_q, kx_d, ky_q, ky_d;
  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;

  // Next counter values: clear loads the frame start, advance steps the scan
  always_comb begin
    kx_d  = kx_q;
    ky_d  = ky_q;
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      kx_d  = '0;
      ky_d  = '0;
      col_d = COL_MIN;
      row_d = ROW_MIN;
    end else if (advance_i) begin
      if (kx_q == 2'd2) begin
        kx_d = '0;
        if (ky_q == 2'd2) begin
          ky_d = '0;
          if (col_q == COL_MAX) begin
            col_d = COL_MIN;
            row_d = (row_q == ROW_MAX) ? ROW_MIN : row_q + COORD_W'(1);
          end else begin
            col_d = col_q + COORD_W'(1);
          end
        end else begin
          ky_d = ky_q + 2'd1;
        end
      end else begin
        kx_d = kx_q + 2'd1;
      end
    end
  end

  // Counter registers, zeroed by reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      kx_q  <= '0;
      ky_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      kx_q  <= kx_d;
      ky_q  <= ky_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign kx_o         = kx_q;
  assign ky_o         = ky_q;
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign last_tap_o   = (kx_q == 2'd2) && (ky_q == 2'd2);
  assign last_pixel_o = last_tap_o && (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/pixel_window_reader.sv
// Raster-scan 3x3 window reader: fetches one tap per cycle from the pixel
// memory and streams it to the conv engine with tap/row/col tags.
// Optional zero padding selected by PIXEL_WIN_PAD_EN (inside pixel_win_counter).
module pixel_window_reader
  import pixel_pkg::*;
#(
  parameter int unsigned PIX_W  = 48,
  parameter int unsigned ADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               read_pixel_signal,
  output logic [ADDR_W-1:0]  pixel_addr,
  input  logic [PIX_W-1:0]   read_pixel_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [PIX_W-1:0]   win_data,
  output logic [3:0]         win_tap,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic               win_last_tap,
  output logic               win_last_pixel
);

  rd_state_t state_q, state_d;

  logic [1:0]         kx, ky;
  logic [COORD_W-1:0] row, col, sr, sc;
  logic               cnt_last_tap, cnt_last_pixel;
  logic               load, clear, src_ok, rd_en;
  logic               row_lo, row_hi, col_lo, col_hi;
  logic [ADDR_W-1:0]  rd_addr, addr_q;

  logic               valid_q, last_tap_q, last_pixel_q;
  logic [PIX_W-1:0]   data_q;
  logic [3:0]         tap_q;
  logic [COORD_W-1:0] row_q, col_q;

  assign load  = (state_q == RUN) && (!valid_q || win_ready);
  assign clear = (state_q == IDLE) && start;

  pixel_win_counter u_cnt (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .advance_i    (load),
    .kx_o         (kx),
    .ky_o         (ky),
    .col_o        (col),
    .row_o        (row),
    .last_tap_o   (cnt_last_tap),
    .last_pixel_o (cnt_last_pixel)
  );

  // Source tap lies outside the image only at the frame border
  assign row_lo  = (row == '0) && (ky == 2'd0);
  assign row_hi  = (row == COORD_W'(IMG_H - 1)) && (ky == 2'd2);
  assign col_lo  = (col == '0) && (kx == 2'd0);
  assign col_hi  = (col == COORD_W'(IMG_W - 1)) && (kx == 2'd2);
  assign src_ok  = !(row_lo || row_hi || col_lo || col_hi);
  assign sr      = row + COORD_W'(ky) - COORD_W'(1);
  assign sc      = col + COORD_W'(kx) - COORD_W'(1);
  assign rd_en   = load && src_ok;
  assign rd_addr = ADDR_W'(pix_addr(RED, sr, sc));

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (load && cnt_last_pixel) state_d = DRAIN;
      DRAIN:   if (valid_q && win_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; address is live on read cycles and held otherwise
  always_comb begin
    busy              = (state_q == RUN) || (state_q == DRAIN);
    done              = (state_q == DONE);
    read_pixel_signal = rd_en;
    pixel_addr        = rd_en ? rd_addr : addr_q;
  end

  // Single-entry output register and held read address
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q       <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      tap_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      last_tap_q   <= 1'b0;
      last_pixel_q <= 1'b0;
    end else begin
      if (rd_en) addr_q <= rd_addr;
      if (load) begin
        valid_q      <= 1'b1;
        data_q       <= src_ok ? read_pixel_data : '0;
        tap_q        <= 4'({ky, 1'b0}) + 4'(ky) + 4'(kx);
        row_q        <= row;
        col_q        <= col;
        last_tap_q   <= cnt_last_tap;
        last_pixel_q <= cnt_last_pixel;
      end else if (win_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign win_valid      = valid_q;
  assign win_data       = data_q;
  assign win_tap        = tap_q;
  assign win_row        = row_q;
  assign win_col        = col_q;
  assign win_last_tap   = last_tap_q;
  assign win_last_pixel = last_pixel_q;

endmodule

// File: tb/tb_pixel_window_reader.sv
// Directed bench for pixel_window_reader; expectations follow the
// PIXEL_WIN_PAD_EN setting of the build.
module tb_pixel_window_reader;

`ifdef PIXEL_WIN_PAD_EN
  localparam int RMIN = 0;
  localparam int RMAX = 31;
`else
  localparam int RMIN = 1;
  localparam int RMAX = 30;
`endif
  localparam int NPOS  = RMAX - RMIN + 1;
  localparam int TOTAL = NPOS * NPOS * 9;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        win_ready = 1'b0;
  logic [47:0] read_pixel_data;
  logic        busy, done, read_pixel_signal, win_valid, win_last_tap, win_last_pixel;
  logic [11:0] pixel_addr;
  logic [47:0] win_data;
  logic [3:0]  win_tap;
  logic [4:0]  win_row, win_col;

  int checks = 0;
  int errors = 0;

  int fr_beats, fr_bad, fr_stall_bad, fr_first_valid, fr_done_cyc, fr_last_hs, fr_first_bad;

  logic [47:0] cap_data [TOTAL];
  logic [3:0]  cap_tap  [TOTAL];
  logic [4:0]  cap_row  [TOTAL];
  logic [4:0]  cap_col  [TOTAL];
  logic        cap_lp   [TOTAL];

  always #5 clk = ~clk;

  pixel_window_reader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .busy              (busy),
    .done              (done),
    .read_pixel_signal (read_pixel_signal),
    .pixel_addr        (pixel_addr),
    .read_pixel_data   (read_pixel_data),
    .win_valid         (win_valid),
    .win_ready         (win_ready),
    .win_data          (win_data),
    .win_tap           (win_tap),
    .win_row           (win_row),
    .win_col           (win_col),
    .win_last_tap      (win_last_tap),
    .win_last_pixel    (win_last_pixel)
  );

  function automatic logic [47:0] pix_val(input int r, input int c);
    logic [15:0] rv;
    rv = 16'(r * 32 + c + 1);
    return {rv + 16'd2048, rv + 16'd1024, rv};
  endfunction

  // Memory model: garbage when no read is issued so padding must not pass it on
  always_comb begin
    if (read_pixel_signal) read_pixel_data = pix_val(int'(pixel_addr[9:5]), int'(pixel_addr[4:0]));
    else                   read_pixel_data = {3{16'hBEEF}};
  end

  function automatic void exp_beat(input int k, output logic [47:0] d, output logic [3:0] tap,
                                   output logic [4:0] row, output logic [4:0] col,
                                   output logic lt, output logic lp);
    int t, pos, r, c, sr, sc;
    t   = k % 9;
    pos = k / 9;
    r   = RMIN + pos / NPOS;
    c   = RMIN + pos % NPOS;
    sr  = r + t / 3 - 1;
    sc  = c + t % 3 - 1;
    tap = 4'(t);
    row = 5'(r);
    col = 5'(c);
    lt  = (t == 8);
    lp  = (k == TOTAL - 1);
    d   = (sr >= 0 && sr < 32 && sc >= 0 && sc < 32) ? pix_val(sr, sc) : 48'd0;
  endfunction

  // Starts a frame and collects beats until done, an abort count, or a cycle limit
  task automatic run_frame(input int rmode, input int abort_at, input int start_at);
    logic [47:0] ed;
    logic [3:0]  et;
    logic [4:0]  er, ec;
    logic        elt, elp;
    logic [64:0] snap, prev;
    bit          prev_stall;
    int          cyc;
    fr_beats = 0; fr_bad = 0; fr_stall_bad = 0;
    fr_first_valid = -1; fr_done_cyc = -1; fr_last_hs = -1; fr_first_bad = -1;
    prev = '0;
    prev_stall = 0;
    @(negedge clk);
    start = 1'b1;
    win_ready = 1'b1;
    cyc = 0;
    while (cyc < 40000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (win_valid && fr_first_valid < 0) fr_first_valid = cyc;
      snap = {win_valid, win_data, win_tap, win_row, win_col, win_last_tap, win_last_pixel};
      if (prev_stall && snap !== prev) fr_stall_bad++;
      if (done) begin
        fr_done_cyc = cyc;
        break;
      end
      if (start_at >= 0 && fr_beats == start_at) start = 1'b1;
      win_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (win_valid && !win_ready && read_pixel_signal) fr_stall_bad++;
      if (win_valid && win_ready) begin
        if (fr_beats < TOTAL) begin
          cap_data[fr_beats] = win_data;
          cap_tap[fr_beats]  = win_tap;
          cap_row[fr_beats]  = win_row;
          cap_col[fr_beats]  = win_col;
          cap_lp[fr_beats]   = win_last_pixel;
          exp_beat(fr_beats, ed, et, er, ec, elt, elp);
          if ({win_data, win_tap, win_row, win_col, win_last_tap, win_last_pixel} !==
              {ed, et, er, ec, elt, elp}) begin
            fr_bad++;
            if (fr_first_bad < 0) fr_first_bad = fr_beats;
          end
        end else begin
          fr_bad++;
        end
        fr_beats++;
        fr_last_hs = cyc;
        if (abort_at >= 0 && fr_beats == abort_at) break;
      end
      prev_stall = win_valid && !win_ready;
      prev = snap;
    end
    win_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    win_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, read_pixel_signal, win_valid, win_last_tap, win_last_pixel} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000000",
               {busy, done, read_pixel_signal, win_valid, win_last_tap, win_last_pixel});
    end
    checks++;
    if (win_data !== 48'd0 || win_tap !== 4'd0) begin
      errors++;
      $display("FAIL reset_data got data=%h tap=%0d expected 0 0", win_data, win_tap);
    end
    checks++;
    if (win_row !== 5'd0 || win_col !== 5'd0 || pixel_addr !== 12'd0) begin
      errors++;
      $display("FAIL reset_tags got row=%0d col=%0d addr=%h expected 0 0 0", win_row, win_col, pixel_addr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    run_frame(0, -1, -1);
    checks++;
    if (fr_beats !== TOTAL) begin
      errors++;
      $display("FAIL full_beats got %0d expected %0d", fr_beats, TOTAL);
    end
    checks++;
    if (fr_bad !== 0) begin
      errors++;
      $display("FAIL full_sequence got %0d bad beats (first %0d) expected 0", fr_bad, fr_first_bad);
    end
    checks++;
    if (fr_first_valid !== 2) begin
      errors++;
      $display("FAIL first_valid_cycle got %0d expected 2", fr_first_valid);
    end
    checks++;
    if (fr_last_hs !== TOTAL + 1 || fr_done_cyc !== TOTAL + 2) begin
      errors++;
      $display("FAIL done_timing got last_hs=%0d done=%0d expected %0d %0d",
               fr_last_hs, fr_done_cyc, TOTAL + 1, TOTAL + 2);
    end
`ifdef PIXEL_WIN_PAD_EN
    checks++;
    if (cap_data[0] !== 48'd0 || cap_tap[0] !== 4'd0 || cap_row[0] !== 5'd0 || cap_col[0] !== 5'd0) begin
      errors++;
      $display("FAIL beat0 got data=%h tap=%0d row=%0d col=%0d expected 0 0 0 0",
               cap_data[0], cap_tap[0], cap_row[0], cap_col[0]);
    end
    checks++;
    if (cap_data[4] !== {16'd2049, 16'd1025, 16'd1}) begin
      errors++;
      $display("FAIL beat4_data got %h expected %h", cap_data[4], {16'd2049, 16'd1025, 16'd1});
    end
`else
    checks++;
    if (cap_data[0] !== {16'd2049, 16'd1025, 16'd1} || cap_tap[0] !== 4'd0 ||
        cap_row[0] !== 5'd1 || cap_col[0] !== 5'd1) begin
      errors++;
      $display("FAIL beat0 got data=%h tap=%0d row=%0d col=%0d expected %h 0 1 1",
               cap_data[0], cap_tap[0], cap_row[0], cap_col[0], {16'd2049, 16'd1025, 16'd1});
    end
    checks++;
    if (cap_data[8099] !== {16'd3072, 16'd2048, 16'd1024} || cap_tap[8099] !== 4'd8 ||
        cap_row[8099] !== 5'd30 || cap_col[8099] !== 5'd30 || cap_lp[8099] !== 1'b1) begin
      errors++;
      $display("FAIL last_beat got data=%h tap=%0d row=%0d col=%0d lp=%b expected %h 8 30 30 1",
               cap_data[8099], cap_tap[8099], cap_row[8099], cap_col[8099], cap_lp[8099],
               {16'd3072, 16'd2048, 16'd1024});
    end
`endif
  endtask

  task automatic test_window_edge();
`ifdef PIXEL_WIN_PAD_EN
    int base;
    base = (31 * 32 + 31) * 9;
    checks++;
    if (cap_data[base] !== {16'd3039, 16'd2015, 16'd991} || cap_row[base] !== 5'd31 || cap_col[base] !== 5'd31) begin
      errors++;
      $display("FAIL corner_tap0 got data=%h row=%0d col=%0d expected %h 31 31",
               cap_data[base], cap_row[base], cap_col[base], {16'd3039, 16'd2015, 16'd991});
    end
    checks++;
    if (cap_data[base + 5] !== 48'd0 || cap_data[base + 7] !== 48'd0 || cap_data[base + 8] !== 48'd0) begin
      errors++;
      $display("FAIL corner_pad got %h %h %h expected 0 0 0",
               cap_data[base + 5], cap_data[base + 7], cap_data[base + 8]);
    end
    checks++;
    if (cap_tap[base + 8] !== 4'd8 || cap_lp[base + 8] !== 1'b1 || cap_lp[base + 7] !== 1'b0) begin
      errors++;
      $display("FAIL corner_last got tap=%0d lp8=%b lp7=%b expected 8 1 0",
               cap_tap[base + 8], cap_lp[base + 8], cap_lp[base + 7]);
    end
`else
    // Centre (1,1) window: tap8 reads pixel(2,2), R = 2*32+2+1 = 67
    checks++;
    if (cap_data[8] !== {16'd2115, 16'd1091, 16'd67} || cap_lp[8] !== 1'b0) begin
      errors++;
      $display("FAIL first_window_tap8 got data=%h lp=%b expected %h 0",
               cap_data[8], cap_lp[8], {16'd2115, 16'd1091, 16'd67});
    end
`endif
  endtask

  task automatic test_random_ready();
    run_frame(1, -1, -1);
    checks++;
    if (fr_beats !== TOTAL || fr_bad !== 0) begin
      errors++;
      $display("FAIL random_sequence got beats=%0d bad=%0d expected %0d 0", fr_beats, fr_bad, TOTAL);
    end
    checks++;
    if (fr_stall_bad !== 0) begin
      errors++;
      $display("FAIL stall_hold got %0d violations expected 0", fr_stall_bad);
    end
    checks++;
    if (fr_done_cyc < 0 || fr_done_cyc !== fr_last_hs + 1) begin
      errors++;
      $display("FAIL random_done got done=%0d expected %0d", fr_done_cyc, fr_last_hs + 1);
    end
  endtask

  task automatic test_reset_mid();
    run_frame(0, 500, -1);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fr_beats !== 500 || {win_valid, busy, read_pixel_signal} !== 3'b000) begin
      errors++;
      $display("FAIL mid_reset got beats=%0d valid/busy/rd=%b expected 500 000",
               fr_beats, {win_valid, busy, read_pixel_signal});
    end
    rst = 1'b1;
    run_frame(0, -1, -1);
    checks++;
    if (cap_tap[0] !== 4'd0 || cap_row[0] !== 5'(RMIN) || cap_col[0] !== 5'(RMIN)) begin
      errors++;
      $display("FAIL restart_beat0 got tap=%0d row=%0d col=%0d expected 0 %0d %0d",
               cap_tap[0], cap_row[0], cap_col[0], RMIN, RMIN);
    end
    checks++;
    if (fr_beats !== TOTAL || fr_bad !== 0) begin
      errors++;
      $display("FAIL restart_frame got beats=%0d bad=%0d expected %0d 0", fr_beats, fr_bad, TOTAL);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(0, -1, 100);
    checks++;
    if (fr_beats !== TOTAL || fr_bad !== 0 || fr_done_cyc !== TOTAL + 2) begin
      errors++;
      $display("FAIL busy_start got beats=%0d bad=%0d done=%0d expected %0d 0 %0d",
               fr_beats, fr_bad, fr_done_cyc, TOTAL, TOTAL + 2);
    end
    run_frame(0, -1, -1);
    checks++;
    if (fr_first_valid !== 2) begin
      errors++;
      $display("FAIL b2b_first_valid got %0d expected 2", fr_first_valid);
    end
    checks++;
    if (fr_beats !== TOTAL || fr_bad !== 0) begin
      errors++;
      $display("FAIL b2b_frame got beats=%0d bad=%0d expected %0d 0", fr_beats, fr_bad, TOTAL);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_window_edge();
    test_random_ready();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
